// File: rtl/regfile_mp_async_rst.sv
// regfile_mp_async_rst
// Parametrised multi-port register file with registered read ports, fixed
// priority write ports, a write-collision pulse and a sticky out-of-range flag.
// An optional hardwired-zero register 0 is selected with ZERO_REG.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a read that hits an address being written on the same edge
//               returns the new data from the highest-priority writer
//   undefined : such a read returns the old register contents and the storage
//               has no forwarding mux
//
// All address and data buses are flat packed vectors:
//   port p address at [p*AW +: AW], port p data at [p*DATA_W +: DATA_W].
module regfile_mp_async_rst #(
    parameter int              DATA_W    = 32,
    parameter int              DEPTH     = 32,
    parameter int              NUM_RD    = 2,
    parameter int              NUM_WR    = 2,
    parameter int              ZERO_REG  = 0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    localparam int             AW        = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic                     wr_collision,
    output logic                     addr_err
);

    // DEPTH need not be a power of two, so an AW-bit address can point past
    // the last register; such accesses are dropped (writes) or read as zero.
    function automatic logic in_range(input logic [AW-1:0] a);
        return (32'(a) < 32'(DEPTH));
    endfunction

    // Register 0 is hardwired to zero only when ZERO_REG is set.
    function automatic logic is_masked(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic [NUM_WR-1:0] wr_ok;
    logic [NUM_WR-1:0] wr_oor;
    logic [NUM_RD-1:0] rd_oor;
    logic [DATA_W-1:0] rd_value [NUM_RD];
    logic              collision_d;
    logic              err_d;

    // Qualify each write port: it commits only when enabled, in range and not
    // aimed at the hardwired-zero register.
    always_comb begin
        wr_ok  = '0;
        wr_oor = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            wr_oor[p] = wr_en[p] && !in_range(wr_addr[p*AW +: AW]);
            wr_ok[p]  = wr_en[p] && in_range(wr_addr[p*AW +: AW])
                        && !is_masked(wr_addr[p*AW +: AW]);
        end
    end

    // Any two enabled writers on the same address count as a collision, even
    // when the target is masked or out of range and nothing gets written.
    always_comb begin
        collision_d = 1'b0;
        for (int p = 0; p < NUM_WR; p++) begin
            for (int q = p + 1; q < NUM_WR; q++) begin
                if (wr_en[p] && wr_en[q] &&
                    (wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW])) begin
                    collision_d = 1'b1;
                end
            end
        end
    end

    // Read data selection per port: zero for masked or out-of-range addresses,
    // otherwise the stored word (optionally overridden by a same-edge write).
    always_comb begin
        rd_oor = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_value[r] = '0;
            rd_oor[r]   = rd_en[r] && !in_range(rd_addr[r*AW +: AW]);
            if (in_range(rd_addr[r*AW +: AW]) && !is_masked(rd_addr[r*AW +: AW])) begin
                rd_value[r] = mem[rd_addr[r*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                // Ascending scan so the highest-indexed matching writer wins,
                // matching the priority used when the storage is updated.
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_ok[w] && (wr_addr[w*AW +: AW] == rd_addr[r*AW +: AW])) begin
                        rd_value[r] = wr_data[w*DATA_W +: DATA_W];
                    end
                end
`endif
            end
        end
    end

    assign err_d = (|wr_oor) || (|rd_oor);

    // Storage array: reset to RESET_VAL (register 0 to zero when masked);
    // later non-blocking writes override earlier ones, so the highest port wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= ((ZERO_REG != 0) && (i == 0)) ? '0 : RESET_VAL;
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_ok[p]) begin
                    mem[wr_addr[p*AW +: AW]] <= wr_data[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Registered read ports: valid follows the request by one cycle and the
    // data register holds its last value while the port is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            for (int r = 0; r < NUM_RD; r++) begin
                rd_valid[r] <= rd_en[r];
                if (rd_en[r]) begin
                    rd_data[r*DATA_W +: DATA_W] <= rd_value[r];
                end
            end
        end
    end

    // One-cycle collision pulse for the edge on which writers clashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_collision <= 1'b0;
        end else begin
            wr_collision <= collision_d;
        end
    end

    // Sticky address error: only a reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if (err_d) begin
            addr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_mp_async_rst.sv
// Testbench for regfile_mp_async_rst.
// Two instances share one stimulus: dut_a with defaults (DEPTH 32, no zero
// register) and dut_b with DEPTH 24, ZERO_REG 1 and a non-zero RESET_VAL.
// Expected values come from an array-based model of the register file.
module tb_regfile_mp_async_rst;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic [NW-1:0]   wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;

    logic [NR*DW-1:0] rd_data_a, rd_data_b;
    logic [NR-1:0]    rd_valid_a, rd_valid_b;
    logic             coll_a, coll_b, err_a, err_b;

    int total = 0;
    int bad   = 0;

    // model state, index k: 0 = dut_a, 1 = dut_b
    logic [DW-1:0] mdl [2][32];
    int            dep [2] = '{32, 24};
    bit            zr  [2] = '{1'b0, 1'b1};
    logic [DW-1:0] rv  [2] = '{32'h0, 32'h1234_5678};
    logic [DW-1:0] exp_data  [2][NR];
    bit            exp_valid [2][NR];
    bit            exp_coll  [2];
    bit            exp_err   [2];

    always #5 clk = ~clk;

    regfile_mp_async_rst dut_a (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_collision(coll_a), .addr_err(err_a)
    );

    regfile_mp_async_rst #(
        .DEPTH(24), .ZERO_REG(1), .RESET_VAL(32'h1234_5678)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_collision(coll_b), .addr_err(err_b)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) mdl[k][i] = (zr[k] && i == 0) ? '0 : rv[k];
            for (int p = 0; p < NR; p++) begin
                exp_data[k][p]  = '0;
                exp_valid[k][p] = 1'b0;
            end
            exp_coll[k] = 1'b0;
            exp_err[k]  = 1'b0;
        end
    endtask

    // Predict what the next rising edge does, from the current inputs.
    task automatic model_step();
        int a;
        logic [DW-1:0] v;
        if (!rst_n) return;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < NR; p++) begin
                exp_valid[k][p] = rd_en[p];
                if (rd_en[p]) begin
                    a = int'(rd_addr[p*AW +: AW]);
                    if (a >= dep[k] || (zr[k] && a == 0)) v = '0;
                    else begin
                        v = mdl[k][a];
`ifdef REGFILE_BYPASS_EN
                        for (int q = 0; q < NW; q++)
                            if (wr_en[q] && int'(wr_addr[q*AW +: AW]) == a) v = wr_data[q*DW +: DW];
`endif
                    end
                    exp_data[k][p] = v;
                    if (a >= dep[k]) exp_err[k] = 1'b1;
                end
            end
            exp_coll[k] = wr_en[0] && wr_en[1] && (wr_addr[0 +: AW] == wr_addr[AW +: AW]);
            for (int q = 0; q < NW; q++) begin
                if (wr_en[q]) begin
                    a = int'(wr_addr[q*AW +: AW]);
                    if (a >= dep[k]) exp_err[k] = 1'b1;
                    else if (!(zr[k] && a == 0)) mdl[k][a] = wr_data[q*DW +: DW];
                end
            end
        end
    endtask

    task automatic check_all();
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("a.rd_valid[%0d]", p), 32'(rd_valid_a[p]), 32'(exp_valid[0][p]));
            chk($sformatf("a.rd_data[%0d]", p), rd_data_a[p*DW +: DW], exp_data[0][p]);
            chk($sformatf("b.rd_valid[%0d]", p), 32'(rd_valid_b[p]), 32'(exp_valid[1][p]));
            chk($sformatf("b.rd_data[%0d]", p), rd_data_b[p*DW +: DW], exp_data[1][p]);
        end
        chk("a.wr_collision", 32'(coll_a), 32'(exp_coll[0]));
        chk("b.wr_collision", 32'(coll_b), 32'(exp_coll[1]));
        chk("a.addr_err", 32'(err_a), 32'(exp_err[0]));
        chk("b.addr_err", 32'(err_b), 32'(exp_err[1]));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        rd_en = '0;
        wr_en = '0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*DW +: DW] = d;
    endtask

    initial begin
        rst_n   = 1'b0;
        rd_en   = '0;
        rd_addr = '0;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // read every address on port 0 after reset
        for (int i = 0; i < 32; i++) begin
            idle();
            set_rd(0, i);
            cycle();
        end
        chk("a.addr_err_after_scan", 32'(err_a), 32'h0);

        // two writers, different addresses, then read both back
        idle();
        set_wr(0, 0, 32'hffff);
        set_wr(1, 2, 32'hfffc);
        cycle();
        idle();
        set_rd(0, 0);
        set_rd(1, 2);
        cycle();
        chk("a.rd0_const", rd_data_a[0 +: DW], 32'h0000ffff);
        chk("a.rd1_const", rd_data_a[DW +: DW], 32'h0000fffc);
        chk("b.rd0_zero_reg", rd_data_b[0 +: DW], 32'h0);

        // same-address collision on 31, port 1 wins
        idle();
        set_wr(0, 31, 32'h1111);
        set_wr(1, 31, 32'h2222);
        cycle();
        chk("a.coll_pulse", 32'(coll_a), 32'h1);
        idle();
        cycle();
        chk("a.coll_cleared", 32'(coll_a), 32'h0);
        set_rd(0, 31);
        cycle();
        chk("a.rd31_const", rd_data_a[0 +: DW], 32'h2222);

        // read-during-write on address 5
        idle();
        set_wr(0, 5, 32'hAAAA);
        cycle();
        idle();
        set_wr(1, 5, 32'h5555);
        set_rd(0, 5);
        cycle();
`ifdef REGFILE_BYPASS_EN
        chk("a.rdw5_const", rd_data_a[0 +: DW], 32'h5555);
`else
        chk("a.rdw5_const", rd_data_a[0 +: DW], 32'hAAAA);
`endif

        // hardwired zero and out-of-range on dut_b
        idle();
        set_wr(0, 0, 32'hdead);
        cycle();
        idle();
        set_rd(1, 0);
        cycle();
        idle();
        set_wr(0, 30, 32'hbeef);
        cycle();
        chk("b.err_set", 32'(err_b), 32'h1);
        idle();
        set_rd(0, 30);
        cycle();
        chk("b.oor_read", rd_data_b[0 +: DW], 32'h0);
        chk("b.oor_valid", 32'(rd_valid_b[0]), 32'h1);
        idle();
        repeat (3) cycle();

        // write 7, then asynchronous reset between edges with a read in flight
        set_wr(0, 7, 32'hfff0);
        set_rd(1, 7);
        cycle();
        idle();
        set_rd(0, 3);
        set_wr(1, 7, 32'h7777);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        cycle();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        set_rd(0, 7);
        cycle();
        chk("a.rd7_after_reset", rd_data_a[0 +: DW], 32'h0);
        chk("b.rd7_after_reset", rd_data_b[0 +: DW], 32'h1234_5678);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rd_en   = NR'($urandom);
            rd_addr = NR*AW'($urandom);
            wr_en   = NW'($urandom);
            wr_data = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) wr_addr = {2{AW'($urandom)}};
            else wr_addr = NW*AW'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp_async_rst.md
Name: regfile_mp_async_rst

Overview:
- Parametrised multi-port register file; next generation of the single-read/single-write 32x32 async-reset register file.
- Adds a configurable width and depth, NUM_RD registered read ports, and NUM_WR write ports with fixed priority.
- Adds collision and out-of-range flags, plus an optional hardwired-zero register.
- Sits between decode/issue and execute. Ports are flat packed vectors so the file can be instantiated at any parameter set.

Parameters:
- DATA_W, 32, bits per register
- DEPTH, 32, number of registers; need not be a power of two; minimum 2
- NUM_RD, 2, read ports; minimum 1
- NUM_WR, 2, write ports; minimum 1
- ZERO_REG, 0, 1 = register 0 reads as 0 and ignores writes
- RESET_VAL, 0, value loaded into every register on reset (DATA_W bits)
- localparam AW = $clog2(DEPTH)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*AW  port p address at [p*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  registered read data, port p at [p*DATA_W +: DATA_W]
- rd_valid  out  NUM_RD  port p data valid, one cycle after rd_en
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*AW  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- wr_collision  out  1  one-cycle pulse: two or more enabled writers hit the same address
- addr_err  out  1  sticky: any enabled read or write used an address >= DEPTH

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - every register = RESET_VAL, except register 0 = 0 when ZERO_REG=1
  - rd_data = 0, rd_valid = 0, wr_collision = 0, addr_err = 0
  - release is synchronous to clk; the first edge with rst_n high performs normal operation
- Write:
  - an enabled port with address < DEPTH updates that register on the rising edge
  - all write ports act in the same cycle
  - same-address conflict: the highest-indexed port wins
  - wr_collision = 1 in the cycle after any conflict, else 0
- Read:
  - latency 1: rd_en[p] at edge N gives rd_data[p] and rd_valid[p]=1 after edge N
  - rd_en[p]=0: rd_valid[p]=0 next cycle and rd_data[p] holds its last value
  - read ports are independent; identical addresses on several ports are legal
- Read-during-write, same address, same edge:
  - returns the pre-write (old) contents unless REGFILE_BYPASS_EN is defined
- ZERO_REG=1:
  - reads of address 0 return 0
  - writes to address 0 are discarded
  - writes to address 0 are still counted in collision detection
- Out-of-range address (>= DEPTH):
  - write is dropped
  - read returns 0 with rd_valid=1
  - addr_err sets and stays set until reset
- Reset mid-operation:
  - in-flight reads are cancelled (rd_valid=0)
  - writes on the reset edge are lost
- No state machine. State consists of:
  - the storage array
  - per-port output registers
  - the collision pulse register
  - the sticky error bit

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: a read whose address matches an enabled, in-range write in the same cycle returns that write's data.
  - Highest-priority writer's data is returned.
  - Applies only to addresses not masked by ZERO_REG.
  - Result: write-then-read has zero extra latency.
- Undefined: such a read returns the old register contents.
  - Storage is plain flops with no forwarding mux.

Test Plan:
- Reset release, DEPTH=32, RESET_VAL=32'h0 -> read all 32 addresses on port 0: 0 each, rd_valid high one cycle after each rd_en, addr_err=0.
- Write port0 addr 0 = 32'hffff, port1 addr 2 = 32'hfffc; next cycle read p0=0, p1=2 -> rd_data p0=32'h0000ffff, p1=32'h0000fffc one cycle later.
- Same edge: wr port0 addr 31 = 32'h1111, port1 addr 31 = 32'h2222 -> wr_collision pulses for one cycle; a later read of 31 = 32'h2222.
- Read-during-write addr 5, old value 32'hAAAA, new value 32'h5555 -> 32'hAAAA without the macro; 32'h5555 with REGFILE_BYPASS_EN defined.
- ZERO_REG=1, DEPTH=24: write addr 0 = 32'hdead -> read returns 0. Write addr 30 -> dropped, addr_err=1 and it stays set. Read addr 30 -> 0 with rd_valid=1.
- Write addr 7 = 32'hfff0, then assert rst_n low between clock edges -> rd_valid drops immediately; after release a read of addr 7 = RESET_VAL and addr_err=0.
